alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 34 +++
 rtl/alu_arbiter.sv | 61 ++++++
 tb/tb_alu_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, shared-ALU and response signals of the two-port ALU arbiter
interface alu_arbiter_if #(parameter int WIDTH = 32);
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0] req0_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0] req1_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0] alu_op;
    logic [WIDTH-1:0] alu_result;
    logic alu_zero;
    logic alu_carry;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ack;
    logic [WIDTH-1:0] rsp_result;
    logic rsp_zero;
    logic rsp_carry;
    logic rsp_err;
    logic busy;
    modport master (
        output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
        output alu_result, alu_zero, alu_carry, rsp_ack,
        input req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_err, busy
    );
    modport slave (
        input req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
        input alu_result, alu_zero, alu_carry, rsp_ack,
        output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_err, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters
module alu_arbiter #(parameter int WIDTH = 32) (
    input logic clk,
    input logic reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state, state_nx;
    logic last_grant, cur_id, g, accept, legal;
    logic [WIDTH-1:0] op_a, op_b, r_result;
    logic [2:0] op_code;
    logic r_zero, r_carry, r_err;
    always_comb begin
        g = &bus.req_valid ? ~last_grant : bus.req_valid[1];
        bus.req_ready = (state == IDLE && !reset && |bus.req_valid) ? (g ? 2'b10 : 2'b01) : 2'b00;
        accept = |(bus.req_valid & bus.req_ready);
        legal = !(op_code inside {3'b011, 3'b100, 3'b101});
        state_nx = state == IDLE ? (accept ? ISSUE : IDLE) :
                   state == ISSUE ? RESP :
                   (bus.rsp_ack[cur_id] ? IDLE : RESP);
        bus.rsp_valid = state == RESP ? (cur_id ? 2'b10 : 2'b01) : 2'b00;
        bus.busy = state != IDLE;
    end
    assign bus.alu_a = op_a;
    assign bus.alu_b = op_b;
    assign bus.alu_op = op_code;
    assign bus.rsp_result = r_result;
    assign bus.rsp_zero = r_zero;
    assign bus.rsp_carry = r_carry;
    assign bus.rsp_err = r_err;
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;
    // last_grant resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a <= '0;
            op_b <= '0;
            op_code <= 3'b000;
            cur_id <= 1'b0;
            last_grant <= 1'b1;
            r_result <= '0;
            r_zero <= 1'b0;
            r_carry <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (accept) begin
                op_a <= g ? bus.req1_a : bus.req0_a;
                op_b <= g ? bus.req1_b : bus.req0_b;
                op_code <= g ? bus.req1_op : bus.req0_op;
                cur_id <= g;
            end
            if (state == ISSUE) begin
                r_result <= legal ? bus.alu_result : '0;
                r_zero <= legal & bus.alu_zero;
                r_carry <= legal & bus.alu_carry;
                r_err <= !legal;
                last_grant <= cur_id;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of the arbiter against a behavioural ALU32Bit model
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    alu_arbiter_if #(32) bus();
    alu_arbiter #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    // illegal opcodes produce a nonzero result and carry so masking is observable
    logic [32:0] sum, diff;
    assign sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    assign diff = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
    assign bus.alu_result = bus.alu_op == 3'b000 ? bus.alu_a & bus.alu_b :
                            bus.alu_op == 3'b001 ? bus.alu_a | bus.alu_b :
                            bus.alu_op == 3'b010 ? sum[31:0] :
                            bus.alu_op == 3'b110 ? diff[31:0] :
                            bus.alu_op == 3'b111 ? {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)} :
                            bus.alu_a ^ bus.alu_b;
    assign bus.alu_zero = bus.alu_result == 32'd0;
    assign bus.alu_carry = bus.alu_op == 3'b010 ? sum[32] :
                           bus.alu_op == 3'b110 ? diff[32] :
                           bus.alu_op == 3'b000 || bus.alu_op == 3'b001 || bus.alu_op == 3'b111 ? 1'b0 : 1'b1;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    initial begin
        bus.req_valid = 2'b00;
        bus.rsp_ack = 2'b00;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = 3'b000;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = 3'b000;
        tick;
        bus.req_valid = 2'b11;
        tick;
        chk("rst_ready", {30'd0, bus.req_ready}, 32'h0);
        chk("rst_busy", {31'd0, bus.busy}, 32'h0);
        chk("rst_rspv", {30'd0, bus.rsp_valid}, 32'h0);
        chk("rst_alu_a", bus.alu_a, 32'h0);
        chk("rst_result", bus.rsp_result, 32'h0);
        reset = 1'b0;
        bus.req_valid = 2'b00;
        // req0 AND; changing req0_b after accept must not leak in
        bus.req_valid = 2'b01;
        bus.req0_a = 32'ha5a5a5a5; bus.req0_b = 32'h5a5a5a5a; bus.req0_op = 3'b000;
        #1 chk("t1_ready", {30'd0, bus.req_ready}, 32'h1);
        tick;
        bus.req_valid = 2'b00;
        bus.req0_b = 32'hffffffff;
        chk("t1_busy", {31'd0, bus.busy}, 32'h1);
        chk("t1_iss_ready", {30'd0, bus.req_ready}, 32'h0);
        chk("t1_iss_rspv", {30'd0, bus.rsp_valid}, 32'h0);
        chk("t1_alu_a", bus.alu_a, 32'ha5a5a5a5);
        chk("t1_alu_b", bus.alu_b, 32'h5a5a5a5a);
        tick;
        chk("t1_rspv", {30'd0, bus.rsp_valid}, 32'h1);
        chk("t1_result", bus.rsp_result, 32'h0);
        chk("t1_zero", {31'd0, bus.rsp_zero}, 32'h1);
        chk("t1_err", {31'd0, bus.rsp_err}, 32'h0);
        bus.rsp_ack = 2'b01;
        tick;
        bus.rsp_ack = 2'b00;
        chk("t1_done_rspv", {30'd0, bus.rsp_valid}, 32'h0);
        chk("t1_done_busy", {31'd0, bus.busy}, 32'h0);
        // req1 ADD, with a wrong-bit ack in RESP
        bus.req_valid = 2'b10;
        bus.req1_a = 32'ha5a5a5a5; bus.req1_b = 32'h5a5a5a5a; bus.req1_op = 3'b010;
        #1 chk("t2_ready", {30'd0, bus.req_ready}, 32'h2);
        tick;
        bus.req_valid = 2'b00;
        tick;
        chk("t2_rspv", {30'd0, bus.rsp_valid}, 32'h2);
        chk("t2_result", bus.rsp_result, 32'hffffffff);
        chk("t2_zero", {31'd0, bus.rsp_zero}, 32'h0);
        chk("t2_carry", {31'd0, bus.rsp_carry}, 32'h0);
        bus.rsp_ack = 2'b01;
        tick;
        chk("t2_wrong_ack", {30'd0, bus.rsp_valid}, 32'h2);
        bus.rsp_ack = 2'b10;
        tick;
        bus.rsp_ack = 2'b00;
        chk("t2_done_rspv", {30'd0, bus.rsp_valid}, 32'h0);
        // round-robin after reset: both continuously valid
        reset = 1'b1;
        tick;
        reset = 1'b0;
        bus.req0_a = 32'ha5a5a5a5; bus.req0_b = 32'ha5a5a5a5; bus.req0_op = 3'b110;
        bus.req1_a = 32'ha5a5a5a5; bus.req1_b = 32'ha5a5a5a5; bus.req1_op = 3'b001;
        bus.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1 chk("rr_ready", {30'd0, bus.req_ready}, (i % 2) ? 32'h2 : 32'h1);
            tick;
            tick;
            chk("rr_rspv", {30'd0, bus.rsp_valid}, (i % 2) ? 32'h2 : 32'h1);
            chk("rr_result", bus.rsp_result, (i % 2) ? 32'ha5a5a5a5 : 32'h0);
            chk("rr_zero", {31'd0, bus.rsp_zero}, (i % 2) ? 32'h0 : 32'h1);
            bus.rsp_ack = (i % 2) ? 2'b10 : 2'b01;
            tick;
            bus.rsp_ack = 2'b00;
        end
        bus.req_valid = 2'b00;
        // illegal opcode still sequences one ISSUE cycle
        bus.req0_a = 32'hffffffff; bus.req0_b = 32'h1; bus.req0_op = 3'b101;
        bus.req_valid = 2'b01;
        tick;
        bus.req_valid = 2'b00;
        chk("t4_alu_op", {29'd0, bus.alu_op}, 32'h5);
        chk("t4_busy", {31'd0, bus.busy}, 32'h1);
        tick;
        chk("t4_rspv", {30'd0, bus.rsp_valid}, 32'h1);
        chk("t4_err", {31'd0, bus.rsp_err}, 32'h1);
        chk("t4_result", bus.rsp_result, 32'h0);
        chk("t4_zero", {31'd0, bus.rsp_zero}, 32'h0);
        chk("t4_carry", {31'd0, bus.rsp_carry}, 32'h0);
        bus.rsp_ack = 2'b01;
        tick;
        bus.rsp_ack = 2'b00;
        // delayed ack with req1 waiting
        bus.req0_op = 3'b010;
        bus.req1_a = 32'h12345678; bus.req1_b = 32'h0; bus.req1_op = 3'b001;
        bus.req_valid = 2'b01;
        tick;
        bus.req_valid = 2'b10;
        tick;
        bus.rsp_ack = 2'b10;
        for (int i = 0; i < 5; i++) begin
            chk("t5_rspv", {30'd0, bus.rsp_valid}, 32'h1);
            chk("t5_result", bus.rsp_result, 32'h0);
            chk("t5_zero", {31'd0, bus.rsp_zero}, 32'h1);
            chk("t5_carry", {31'd0, bus.rsp_carry}, 32'h1);
            chk("t5_ready", {30'd0, bus.req_ready}, 32'h0);
            chk("t5_busy", {31'd0, bus.busy}, 32'h1);
            tick;
        end
        bus.rsp_ack = 2'b01;
        tick;
        bus.rsp_ack = 2'b00;
        chk("t5_next_ready", {30'd0, bus.req_ready}, 32'h2);
        tick;
        bus.req_valid = 2'b00;
        tick;
        chk("t5_r1_rspv", {30'd0, bus.rsp_valid}, 32'h2);
        chk("t5_r1_result", bus.rsp_result, 32'h12345678);
        bus.rsp_ack = 2'b10;
        tick;
        bus.rsp_ack = 2'b00;
        // reset in RESP aborts and restores requester 0 priority
        bus.req0_a = 32'hffffffff; bus.req0_b = 32'hffffffff; bus.req0_op = 3'b000;
        bus.req_valid = 2'b01;
        tick;
        bus.req_valid = 2'b00;
        tick;
        chk("t6_rspv", {30'd0, bus.rsp_valid}, 32'h1);
        chk("t6_result", bus.rsp_result, 32'hffffffff);
        reset = 1'b1;
        bus.req_valid = 2'b11;
        tick;
        reset = 1'b0;
        #1;
        chk("t6_rst_rspv", {30'd0, bus.rsp_valid}, 32'h0);
        chk("t6_rst_busy", {31'd0, bus.busy}, 32'h0);
        chk("t6_rst_result", bus.rsp_result, 32'h0);
        chk("t6_tie_ready", {30'd0, bus.req_ready}, 32'h1);
        tick;
        bus.req_valid = 2'b00;
        tick;
        chk("t6_after_rspv", {30'd0, bus.rsp_valid}, 32'h1);
        bus.rsp_ack = 2'b01;
        tick;
        bus.rsp_ack = 2'b00;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
